// File: rtl/fft_bfly_sequencer.sv
// Butterfly address sequencer for a 256-point radix-2 in-place FFT.
// Walks 8 stages x 128 butterflies, drains the datapath between stages, and drives the stage counter.
module fft_bfly_sequencer #(
  parameter int unsigned PIPE_DRAIN = 4
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       start,
  input  logic [2:0] stage_count_in,
  input  logic       bfly_ready,
  output logic       bfly_valid,
  output logic [7:0] addr_a,
  output logic [7:0] addr_b,
  output logic [6:0] tw_addr,
  output logic       stage_strobe,
  output logic       stage_clear,
  output logic       busy,
  output logic       fft_done
);

  typedef enum logic [2:0] {StIdle, StClr, StRun, StDrain, StDone} state_e;

  localparam logic [3:0] DrainLoad = 4'(PIPE_DRAIN);

  state_e     state_q;
  logic [6:0] k_q;
  logic [3:0] drain_q;
  logic       last_stage_q;
  logic       valid_q, strobe_q, clear_q, busy_q, done_q;

  logic [7:0] k_ext, half, pos, a_raw;
  logic [6:0] tw_raw;
  logic [3:0] s_p1;

  // Insert a zero bit at position s of k to get the top leg; bottom leg sits half above it.
  always_comb begin
    s_p1   = {1'b0, stage_count_in} + 4'd1;
    k_ext  = {1'b0, k_q};
    half   = 8'd1 << stage_count_in;
    pos    = k_ext & (half - 8'd1);
    a_raw  = ((k_ext >> stage_count_in) << s_p1) | pos;
    tw_raw = pos[6:0] << (3'd7 - stage_count_in);
  end

  // Addresses are forced to zero whenever nothing is offered, which also gives all-zero reset outputs.
  assign bfly_valid   = valid_q;
  assign addr_a       = valid_q ? a_raw : 8'd0;
  assign addr_b       = valid_q ? (a_raw + half) : 8'd0;
  assign tw_addr      = valid_q ? tw_raw : 7'd0;
  assign stage_strobe = strobe_q;
  assign stage_clear  = clear_q;
  assign busy         = busy_q;
  assign fft_done     = done_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= StIdle;
      k_q          <= 7'd0;
      drain_q      <= 4'd0;
      last_stage_q <= 1'b0;
      valid_q      <= 1'b0;
      strobe_q     <= 1'b0;
      clear_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      clear_q  <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StClr;
            clear_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StClr: begin
          k_q     <= 7'd0;
          valid_q <= 1'b1;
          state_q <= StRun;
        end
        StRun: begin
          if (bfly_ready) begin
            k_q <= k_q + 7'd1;
            if (k_q == 7'd127) begin
              last_stage_q <= (stage_count_in == 3'd7);
              drain_q      <= DrainLoad;
              valid_q      <= 1'b0;
              strobe_q     <= 1'b1;
              state_q      <= StDrain;
            end
          end
        end
        StDrain: begin
          drain_q <= drain_q - 4'd1;
          if (drain_q == 4'd1) begin
            if (last_stage_q) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              valid_q <= 1'b1;
              state_q <= StRun;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Bench for fft_bfly_sequencer: two instances (PIPE_DRAIN 4 and 1), each with its own stage counter,
// checked against a timeline/scoreboard model built from the butterfly indexing rules.
module tb_fft_bfly_sequencer;

  logic clk = 1'b0;
  logic n_reset, start, bfly_ready;
  logic [2:0] sc4, sc1;
  logic v4, st4, cl4, bu4, dn4, v1, st1, cl1, bu1, dn1;
  logic [7:0] a4, b4, a1, b1;
  logic [6:0] tw4, tw1;
  int checks = 0;
  int errors = 0;

  // {valid, addr_a, addr_b, tw, strobe, clear, busy, done}
  localparam logic [27:0] CtrlMask = {1'b1, 23'd0, 4'hf};

  always #5 clk = ~clk;

  fft_bfly_sequencer #(.PIPE_DRAIN(4)) dut4 (
    .clk(clk), .n_reset(n_reset), .start(start), .stage_count_in(sc4), .bfly_ready(bfly_ready),
    .bfly_valid(v4), .addr_a(a4), .addr_b(b4), .tw_addr(tw4), .stage_strobe(st4),
    .stage_clear(cl4), .busy(bu4), .fft_done(dn4)
  );

  fft_bfly_sequencer #(.PIPE_DRAIN(1)) dut1 (
    .clk(clk), .n_reset(n_reset), .start(start), .stage_count_in(sc1), .bfly_ready(bfly_ready),
    .bfly_valid(v1), .addr_a(a1), .addr_b(b1), .tw_addr(tw1), .stage_strobe(st1),
    .stage_clear(cl1), .busy(bu1), .fft_done(dn1)
  );

  // Stage counters downstream of each sequencer.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) sc4 <= 3'd0;
    else if (cl4) sc4 <= 3'd0;
    else if (st4) sc4 <= sc4 + 3'd1;
  end
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) sc1 <= 3'd0;
    else if (cl1) sc1 <= 3'd0;
    else if (st1) sc1 <= sc1 + 3'd1;
  end

  wire [27:0] vec4 = {v4, a4, b4, tw4, st4, cl4, bu4, dn4};
  wire [27:0] vec1 = {v1, a1, b1, tw1, st1, cl1, bu1, dn1};

  function automatic logic [27:0] addr_vec(int s, int k);
    int h, a;
    h = 1 << s;
    a = (k / h) * 2 * h + k % h;
    return {1'b1, 8'(a), 8'(a + h), 7'((k % h) * (128 / h)), 4'b0010};
  endfunction

  // Expected outputs in cycle cyc (0 = CLR) with bfly_ready held high.
  function automatic logic [27:0] exp_vec(int d, int cyc);
    int per, r;
    per = 128 + d;
    if (cyc == 0) return 28'h0000006;
    if (cyc <= 8 * per) begin
      r = cyc - 1;
      if (r % per < 128) return addr_vec(r / per, r % per);
      if (r % per == 128) return 28'h000000a;
      return 28'h0000002;
    end
    if (cyc == 8 * per + 1) return 28'h0000003;
    return 28'h0;
  endfunction

  function automatic logic [27:0] mask_for(logic [27:0] e);
    return e[27] ? 28'hfffffff : CtrlMask;
  endfunction

  task automatic wait_idle();
    int n;
    bfly_ready = 1'b1;
    start = 1'b0;
    n = 0;
    @(negedge clk);
    while ((bu4 || bu1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bu4 !== 1'b0 || bu1 !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy4=%0b busy1=%0b required 0", bu4, bu1);
    end
  endtask

  // Called at a negedge with both idle; returns at the negedge of cycle 0 (CLR).
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0;
    bfly_ready = 1'b0;
    n_reset = 1'b0;
    @(negedge clk);
    checks++;
    if (vec4 !== 28'h0 || vec1 !== 28'h0) begin
      errors++;
      $display("FAIL reset_init got4=%h got1=%h required 0", vec4, vec1);
    end
    n_reset = 1'b1;
    wait_idle();
    do_start();
    repeat (437) @(negedge clk);
    checks++;
    if (vec4 !== exp_vec(4, 437)) begin
      errors++;
      $display("FAIL reset_pre got=%h required=%h", vec4, exp_vec(4, 437));
    end
    n_reset = 1'b0;
    #1;
    checks++;
    if (vec4 !== 28'h0 || vec1 !== 28'h0) begin
      errors++;
      $display("FAIL reset_async got4=%h got1=%h required 0", vec4, vec1);
    end
    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (vec4 !== 28'h0 || vec1 !== 28'h0) begin
        errors++;
        $display("FAIL reset_after i=%0d got4=%h got1=%h required 0", i, vec4, vec1);
      end
    end
  endtask

  task automatic test_full_fft();
    int hs4, hs1, ns4, ns1;
    logic [27:0] e4, e1;
    hs4 = 0; hs1 = 0; ns4 = 0; ns1 = 0;
    wait_idle();
    do_start();
    for (int c = 0; c <= 1070; c++) begin
      e4 = exp_vec(4, c);
      e1 = exp_vec(1, c);
      checks++;
      if ((vec4 & mask_for(e4)) !== (e4 & mask_for(e4))) begin
        errors++;
        $display("FAIL full_d4 cyc=%0d got=%h required=%h", c, vec4 & mask_for(e4), e4);
      end
      checks++;
      if ((vec1 & mask_for(e1)) !== (e1 & mask_for(e1))) begin
        errors++;
        $display("FAIL full_d1 cyc=%0d got=%h required=%h", c, vec1 & mask_for(e1), e1);
      end
      if (v4 && bfly_ready) hs4++;
      if (v1 && bfly_ready) hs1++;
      if (st4) ns4++;
      if (st1) ns1++;
      @(negedge clk);
    end
    checks++;
    if (hs4 != 1024 || hs1 != 1024) begin
      errors++;
      $display("FAIL full_handshakes got4=%0d got1=%0d required 1024", hs4, hs1);
    end
    checks++;
    if (ns4 != 8 || ns1 != 8) begin
      errors++;
      $display("FAIL full_strobes got4=%0d got1=%0d required 8", ns4, ns1);
    end
  endtask

  task automatic test_addr_stall();
    logic [27:0] hold;
    wait_idle();
    do_start();
    repeat (272) @(negedge clk);
    hold = addr_vec(2, 7);
    checks++;
    if (vec4 !== hold) begin
      errors++;
      $display("FAIL stall_entry got=%h required=%h", vec4, hold);
    end
    bfly_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (vec4 !== hold) begin
        errors++;
        $display("FAIL stall_hold i=%0d got=%h required=%h", i, vec4, hold);
      end
    end
    bfly_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (vec4 !== addr_vec(2, 8)) begin
      errors++;
      $display("FAIL stall_resume got=%h required=%h", vec4, addr_vec(2, 8));
    end
  endtask

  task automatic test_random_stall();
    int hs, drain_left, cyc;
    logic pend_strobe, done_seen, exp_v, exp_dn;
    logic [27:0] e;
    wait_idle();
    do_start();
    checks++;
    if (cl4 !== 1'b1) begin
      errors++;
      $display("FAIL rand_clear got=%0b required 1", cl4);
    end
    bfly_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    hs = 0; drain_left = 0; cyc = 0; pend_strobe = 1'b0; done_seen = 1'b0;
    while (!done_seen && cyc < 6000) begin
      exp_v  = (hs < 1024) && (drain_left == 0);
      exp_dn = (hs == 1024) && (drain_left == 0);
      e = exp_v ? addr_vec(hs / 128, hs % 128) : {24'd0, pend_strobe, 1'b0, 1'b1, exp_dn};
      checks++;
      if ((vec4 & mask_for(e)) !== (e & mask_for(e))) begin
        errors++;
        $display("FAIL rand cyc=%0d hs=%0d got=%h required=%h", cyc, hs, vec4 & mask_for(e), e);
      end
      if (exp_dn) done_seen = 1'b1;
      pend_strobe = 1'b0;
      if (drain_left > 0) drain_left--;
      bfly_ready = ($urandom_range(0, 3) != 0);
      if (exp_v && bfly_ready) begin
        if (hs % 128 == 127) begin
          drain_left = 4;
          pend_strobe = 1'b1;
        end
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!done_seen || bu4 !== 1'b0 || v4 !== 1'b0) begin
      errors++;
      $display("FAIL rand_end done_seen=%0b busy=%0b valid=%0b required 1/0/0", done_seen, bu4, v4);
    end
  endtask

  task automatic test_start_ignored();
    logic [27:0] e;
    wait_idle();
    do_start();
    for (int c = 0; c <= 1060; c++) begin
      e = (c == 1060) ? exp_vec(4, 0) : exp_vec(4, c);
      checks++;
      if ((vec4 & mask_for(e)) !== (e & mask_for(e))) begin
        errors++;
        $display("FAIL start_ign cyc=%0d got=%h required=%h", c, vec4 & mask_for(e), e);
      end
      start = (c == 50 || c == 130 || c == 1057 || c == 1059);
      if (c < 1060) @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_fft();
    test_addr_stall();
    test_random_stall();
    test_start_ignored();
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
